// File: rtl/ball_motion_if.sv
// Signal bundle between the video timing / game logic (master) and the ball motion block (slave).
interface ball_motion_if;
  logic       clock;
  logic [7:0] hcnt;
  logic [7:0] vcnt;
  logic       vsync;
  logic       serve;
  logic       pad_hit;
  logic [1:0] pad_seg;
  logic       brick_hit;
  logic       speed_up;
  logic       ball_display;
  logic [7:0] ball_h;
  logic [7:0] ball_v;
  logic       ball_lost;
  logic [1:0] state;

  modport master (
    output clock, hcnt, vcnt, vsync, serve, pad_hit, pad_seg, brick_hit, speed_up,
    input  ball_display, ball_h, ball_v, ball_lost, state
  );

  modport slave (
    input  clock, hcnt, vcnt, vsync, serve, pad_hit, pad_seg, brick_hit, speed_up,
    output ball_display, ball_h, ball_v, ball_lost, state
  );
endinterface

// File: rtl/ball_motion.sv
// Ball position/motion generator: draws the ball from the video counters and moves it
// once per frame with wall, ceiling, paddle and brick bounces; flags a lost ball.
module ball_motion #(
  parameter int BALL_SIZE = 4,
  parameter int H_LEFT    = 16,
  parameter int H_RIGHT   = 240,
  parameter int V_TOP     = 32,
  parameter int V_BOTTOM  = 248,
  parameter int SERVE_H   = 128,
  parameter int SERVE_V   = 128
) (
  input  logic         clk_drv,
  input  logic         clr_n,
  ball_motion_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LOST   = 2'd2
  } state_t;

  localparam logic [7:0]        H_MIN  = 8'(H_LEFT);
  localparam logic [7:0]        H_MAX  = 8'(H_RIGHT - BALL_SIZE);
  localparam logic [7:0]        V_MIN  = 8'(V_TOP);
  localparam logic [7:0]        V_CEIL = 8'hFF;
  localparam logic signed [9:0] V_LOST = 10'(V_BOTTOM);
  localparam logic [7:0]        SIZE   = 8'(BALL_SIZE);
  localparam logic [7:0]        HOME_H = 8'(SERVE_H);
  localparam logic [7:0]        HOME_V = 8'(SERVE_V);

  // One step of position math, widened so under/overflow is visible before clamping.
  function automatic logic signed [9:0] step(input logic [7:0] pos, input logic signed [2:0] d);
    return $signed({2'b00, pos}) + $signed({{7{d[2]}}, d});
  endfunction

  function automatic logic [7:0] sat_pos(input logic signed [9:0] n,
                                         input logic [7:0]        lo,
                                         input logic [7:0]        hi);
    if (n < $signed({2'b00, lo})) return lo;
    if (n > $signed({2'b00, hi})) return hi;
    return n[7:0];
  endfunction

  function automatic logic signed [2:0] seg_dx(input logic [1:0] seg);
    case (seg)
      2'd0:    return 3'sb110;
      2'd1:    return 3'sb111;
      2'd2:    return 3'sb001;
      default: return 3'sb010;
    endcase
  endfunction

  state_t            state;
  logic              clock_q;
  logic              vsync_q;
  logic [7:0]        ball_h;
  logic [7:0]        ball_v;
  logic signed [2:0] dx;
  logic signed [2:0] dy;
  logic              fast;
  logic              pad_l;
  logic [1:0]        pad_seg_l;
  logic              brick_l;
  logic              ball_display;
  logic              ball_lost;

  logic              pix_tick;
  logic              frame_tick;
  logic [7:0]        dh;
  logic [7:0]        dv;
  logic              in_ball;

  assign pix_tick   = bus.clock & ~clock_q;
  assign frame_tick = pix_tick & bus.vsync & ~vsync_q;

  // Unsigned wrap makes pixels left of / above the ball land far outside the size window.
  assign dh      = bus.hcnt - ball_h;
  assign dv      = bus.vcnt - ball_v;
  assign in_ball = (dh < SIZE) && (dv < SIZE);

  logic              fast_nxt;
  logic signed [2:0] mag;
  logic signed [2:0] dx_dir;
  logic signed [2:0] dy_dir;
  logic signed [9:0] nh;
  logic signed [9:0] nv;
  logic              wall_hit;
  logic              ceil_hit;
  logic [7:0]        h_nxt;
  logic [7:0]        v_nxt;
  logic signed [2:0] dx_nxt;
  logic signed [2:0] dy_nxt;
  logic              lost_nxt;

  // Direction first (paddle beats brick), then move and clamp; the clamp may reverse again.
  always_comb begin
    fast_nxt = fast | bus.speed_up;
    mag      = fast_nxt ? 3'sd2 : 3'sd1;
    dx_dir   = dx;
    dy_dir   = dy[2] ? -mag : mag;
    if (pad_l) begin
      dx_dir = seg_dx(pad_seg_l);
      dy_dir = -mag;
    end else if (brick_l) begin
      dy_dir = dy[2] ? mag : -mag;
    end
    nh       = step(ball_h, dx_dir);
    nv       = step(ball_v, dy_dir);
    wall_hit = (nh < $signed({2'b00, H_MIN})) || (nh > $signed({2'b00, H_MAX}));
    ceil_hit = nv < $signed({2'b00, V_MIN});
    h_nxt    = sat_pos(nh, H_MIN, H_MAX);
    v_nxt    = sat_pos(nv, V_MIN, V_CEIL);
    dx_nxt   = wall_hit ? -dx_dir : dx_dir;
    dy_nxt   = ceil_hit ? mag : dy_dir;
    lost_nxt = nv >= V_LOST;
  end

  always_ff @(posedge clk_drv or negedge clr_n) begin
    if (!clr_n) begin
      state        <= IDLE;
      clock_q      <= 1'b0;
      vsync_q      <= 1'b0;
      ball_h       <= HOME_H;
      ball_v       <= HOME_V;
      dx           <= 3'sd1;
      dy           <= 3'sd1;
      fast         <= 1'b0;
      pad_l        <= 1'b0;
      pad_seg_l    <= 2'd0;
      brick_l      <= 1'b0;
      ball_display <= 1'b0;
      ball_lost    <= 1'b0;
    end else begin
      clock_q   <= bus.clock;
      ball_lost <= 1'b0;

      if (pix_tick) begin
        vsync_q      <= bus.vsync;
        ball_display <= (state == ACTIVE) && in_ball;
      end

      // Hits arriving on the frame-tick pixel itself belong to no decided frame and are dropped.
      if (pix_tick && !frame_tick && state == ACTIVE) begin
        if (bus.pad_hit && !pad_l) pad_seg_l <= bus.pad_seg;
        pad_l   <= pad_l | bus.pad_hit;
        brick_l <= brick_l | bus.brick_hit;
      end

      if (frame_tick) begin
        pad_l   <= 1'b0;
        brick_l <= 1'b0;
        case (state)
          IDLE: begin
            if (bus.serve) begin
              ball_h <= HOME_H;
              ball_v <= HOME_V;
              dx     <= 3'sd1;
              dy     <= 3'sd1;
              fast   <= 1'b0;
              state  <= ACTIVE;
            end
          end
          ACTIVE: begin
            fast   <= fast_nxt;
            ball_h <= h_nxt;
            ball_v <= v_nxt;
            dx     <= dx_nxt;
            dy     <= dy_nxt;
            if (lost_nxt) begin
              state     <= LOST;
              ball_lost <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ball_display = ball_display;
  assign bus.ball_h       = ball_h;
  assign bus.ball_v       = ball_v;
  assign bus.ball_lost    = ball_lost;
  assign bus.state        = state;

endmodule
